// File: rtl/stream_pack_upsizer.sv
// stream_pack_upsizer: packs SCALE narrow beats of DW_IN bits into one DW_IN*SCALE-bit word.
// A word is emitted when all lanes are filled, when a beat carries s_last_i, or on a flush
// request while lanes are partially filled. Unfilled lanes are zero and flagged off in m_keep_o.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_data_i/s_valid_i/s_last_i/s_ready_o   narrow input stream
//   flush_i             single-cycle request to emit the partial word
//   m_data_o/m_keep_o/m_last_o/m_valid_o/m_ready_i   wide output stream (registered)
module stream_pack_upsizer #(
  parameter int unsigned DW_IN      = 8,
  parameter int unsigned SCALE      = 4,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW_IN-1:0]       s_data_i,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  output logic                   s_ready_o,
  input  logic                   flush_i,
  output logic [DW_IN*SCALE-1:0] m_data_o,
  output logic [SCALE-1:0]       m_keep_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i
);

  localparam int unsigned IdxW = (SCALE > 1) ? $clog2(SCALE) : 1;

  // Assembly stage
  logic [SCALE-1:0][DW_IN-1:0] asm_data_q, asm_data_d, asm_merged;
  logic [SCALE-1:0]            asm_mask_q, asm_mask_d, mask_merged;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        rst_r_q;

  // Output stage
  logic [SCALE-1:0][DW_IN-1:0] out_data_q, out_data_d;
  logic [SCALE-1:0]            out_keep_q, out_keep_d;
  logic                        out_last_q, out_last_d;
  logic                        out_full_q, out_full_d;

  logic wr, rd, can_load, complete, flush_exec, load;

  always_comb begin
    // The output register can take a new word if it is empty or being drained this cycle.
    can_load   = !out_full_q || m_ready_i;
    s_ready_o  = !rst_r_q && can_load;
    wr         = s_valid_i && s_ready_o;
    rd         = out_full_q && m_ready_i;

    // Assembly contents including any beat accepted this cycle.
    asm_merged  = asm_data_q;
    mask_merged = asm_mask_q;
    if (wr) begin
      asm_merged[idx_q]  = s_data_i;
      mask_merged[idx_q] = 1'b1;
    end

    complete   = wr && ((idx_q == IdxW'(SCALE - 1)) || s_last_i);
    flush_exec = (flush_pend_q || flush_i) && can_load;
    load       = complete || (flush_exec && (|mask_merged));

    asm_data_d   = asm_data_q;
    asm_mask_d   = asm_mask_q;
    idx_d        = idx_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_full_d   = out_full_q;
    flush_pend_d = flush_exec ? 1'b0 : (flush_pend_q || flush_i);

    if (load) begin
      out_data_d = asm_merged;
      out_keep_d = mask_merged;
      out_last_d = wr && s_last_i;
      out_full_d = 1'b1;
      asm_data_d = '0;
      asm_mask_d = '0;
      idx_d      = '0;
    end else begin
      if (wr) begin
        asm_data_d = asm_merged;
        asm_mask_d = mask_merged;
        idx_d      = idx_q + IdxW'(1);
      end
      if (rd) begin
        out_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data_q   <= '0;
      asm_mask_q   <= '0;
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
      rst_r_q      <= 1'b1;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_full_q   <= 1'b0;
    end else begin
      asm_data_q   <= asm_data_d;
      asm_mask_q   <= asm_mask_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
      rst_r_q      <= 1'b0;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_full_q   <= out_full_d;
    end
  end

  // Lane order is only reversed at the output; internally lane 0 is always the first beat.
  always_comb begin
    m_data_o = '0;
    m_keep_o = '0;
    for (int i = 0; i < int'(SCALE); i++) begin
      if (BIG_ENDIAN) begin
        m_data_o[i*DW_IN +: DW_IN] = out_data_q[int'(SCALE) - 1 - i];
        m_keep_o[i]                = out_keep_q[int'(SCALE) - 1 - i];
      end else begin
        m_data_o[i*DW_IN +: DW_IN] = out_data_q[i];
        m_keep_o[i]                = out_keep_q[i];
      end
    end
  end

  assign m_last_o  = out_last_q;
  assign m_valid_o = out_full_q;

endmodule

// File: tb/tb_stream_pack_upsizer.sv
// Bench for stream_pack_upsizer: little- and big-endian instances share one input stream and
// are checked every cycle against a queue-based model, plus directed literal expectations.
module tb_stream_pack_upsizer;

  localparam int DW = 8;
  localparam int SC = 4;
  localparam int W  = DW * SC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;

  logic          s_ready_le, s_ready_be, m_last_le, m_last_be, m_valid_le, m_valid_be;
  logic [W-1:0]  m_data_le, m_data_be;
  logic [SC-1:0] m_keep_le, m_keep_be;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_pack_upsizer #(.DW_IN(DW), .SCALE(SC), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
    .s_ready_o(s_ready_le), .flush_i(flush), .m_data_o(m_data_le), .m_keep_o(m_keep_le),
    .m_last_o(m_last_le), .m_valid_o(m_valid_le), .m_ready_i(m_ready)
  );

  stream_pack_upsizer #(.DW_IN(DW), .SCALE(SC), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
    .s_ready_o(s_ready_be), .flush_i(flush), .m_data_o(m_data_be), .m_keep_o(m_keep_be),
    .m_last_o(m_last_be), .m_valid_o(m_valid_be), .m_ready_i(m_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev_data(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < SC; i++) r[i*DW +: DW] = d[(SC-1-i)*DW +: DW];
    return r;
  endfunction

  function automatic logic [SC-1:0] rev_keep(input logic [SC-1:0] k);
    logic [SC-1:0] r;
    for (int i = 0; i < SC; i++) r[i] = k[SC-1-i];
    return r;
  endfunction

  // Model: pending beats in a queue, one word register.
  logic [DW-1:0] m_beats[$];
  logic          m_ov, m_lst, m_pend, m_rstr;
  logic [W-1:0]  m_dat;
  logic [SC-1:0] m_kp;

  always @(posedge clk or posedge rst) begin : model
    logic rdy, wr, ld;
    if (rst) begin
      m_beats.delete();
      m_ov = 1'b0; m_lst = 1'b0; m_pend = 1'b0; m_rstr = 1'b1;
      m_dat = '0; m_kp = '0;
    end else begin
      rdy = !m_rstr && (!m_ov || m_ready);
      wr  = s_valid && rdy;
      ld  = 1'b0;
      if (wr) begin
        m_beats.push_back(s_data);
        if (m_beats.size() == SC || s_last) ld = 1'b1;
      end
      if ((m_pend || flush) && (!m_ov || m_ready)) begin
        if (m_beats.size() != 0) ld = 1'b1;
        m_pend = 1'b0;
      end else if (flush) begin
        m_pend = 1'b1;
      end
      if (ld) begin
        m_dat = '0;
        foreach (m_beats[i]) m_dat[i*DW +: DW] = m_beats[i];
        m_kp  = SC'((1 << m_beats.size()) - 1);
        m_lst = wr && s_last;
        m_ov  = 1'b1;
        m_beats.delete();
      end else if (m_ov && m_ready) begin
        m_ov = 1'b0;
      end
      m_rstr = 1'b0;
    end
  end

  logic [W-1:0] got[$];
  logic         streaming = 1'b0;
  int           stalls = 0;

  always @(negedge clk) begin : compare
    logic exp_rdy;
    exp_rdy = !m_rstr && (!m_ov || m_ready);
    chk("s_ready_le", 64'(s_ready_le), 64'(exp_rdy));
    chk("s_ready_be", 64'(s_ready_be), 64'(exp_rdy));
    chk("m_valid_le", 64'(m_valid_le), 64'(m_ov));
    chk("m_valid_be", 64'(m_valid_be), 64'(m_ov));
    if (m_ov || rst) begin
      chk("m_data_le", 64'(m_data_le), 64'(m_dat));
      chk("m_keep_le", 64'(m_keep_le), 64'(m_kp));
      chk("m_last_le", 64'(m_last_le), 64'(m_lst));
      chk("m_data_be", 64'(m_data_be), 64'(rev_data(m_dat)));
      chk("m_keep_be", 64'(m_keep_be), 64'(rev_keep(m_kp)));
      chk("m_last_be", 64'(m_last_be), 64'(m_lst));
    end
    if (m_valid_le && m_ready) got.push_back(m_data_le);
    if (streaming && !s_ready_le) stalls++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold a beat until it is accepted; returns 2 time units after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic last);
    logic acc;
    int   n;
    s_valid = 1'b1; s_data = d; s_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      acc = s_ready_le;
      @(posedge clk);
      #2;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'(n), 64'(0));
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] d_le, input logic [SC-1:0] k_le,
                          input logic last);
    chk({name, "_valid"}, 64'(m_valid_le), 64'(1));
    chk({name, "_data"}, 64'(m_data_le), 64'(d_le));
    chk({name, "_keep"}, 64'(m_keep_le), 64'(k_le));
    chk({name, "_last"}, 64'(m_last_le), 64'(last));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int left, len;
    m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 64'(s_ready_le), 64'(0));
    chk("rst_valid", 64'(m_valid_le), 64'(0));
    chk("rst_data", 64'(m_data_le), 64'(0));
    rst = 1'b0;
    chk("post_rst_ready0", 64'(s_ready_le), 64'(0));
    tick();
    chk("post_rst_ready1", 64'(s_ready_le), 64'(1));

    // Full word, little endian
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("no_early_valid", 64'(m_valid_le), 64'(0));
    send(8'h44, 0);
    chk_word("full", 32'h44332211, 4'b1111, 1'b0);
    chk("full_be_data", 64'(m_data_be), 64'(32'h11223344));
    tick();
    chk("full_drained", 64'(m_valid_le), 64'(0));

    // Short packet, then new packet starts in lane 0
    send(8'hA1, 0); send(8'hA2, 1);
    chk_word("pkt2", 32'h0000A2A1, 4'b0011, 1'b1);
    send(8'hB1, 1);
    chk_word("pkt1", 32'h000000B1, 4'b0001, 1'b1);
    tick();

    // Flush of a partial word, then flush with nothing assembled
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_be_valid", 64'(m_valid_be), 64'(1));
    chk("flush_be_data", 64'(m_data_be), 64'(32'h11223300));
    chk("flush_be_keep", 64'(m_keep_be), 64'(4'b1110));
    chk("flush_be_last", 64'(m_last_be), 64'(0));
    chk("flush_le_data", 64'(m_data_le), 64'(32'h00332211));
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("empty_flush0", 64'(m_valid_le), 64'(0));
    tick();
    chk("empty_flush1", 64'(m_valid_le), 64'(0));

    // Backpressure: word held, 12 beats wait, then drain in order
    got.delete();
    m_ready = 1'b0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    fork
      begin
        for (int i = 0; i < 12; i++) send(8'(8'h50 + i), 1'b0);
      end
      begin
        repeat (6) begin
          tick();
          chk("bp_ready_low", 64'(s_ready_le), 64'(0));
          chk("bp_hold_data", 64'(m_data_le), 64'(32'h44332211));
        end
        m_ready = 1'b1;
      end
    join
    tick(); tick();
    chk("bp_words", 64'(got.size()), 64'(4));
    if (got.size() == 4) begin
      chk("bp_w0", 64'(got[0]), 64'(32'h44332211));
      chk("bp_w1", 64'(got[1]), 64'(32'h53525150));
      chk("bp_w2", 64'(got[2]), 64'(32'h57565554));
      chk("bp_w3", 64'(got[3]), 64'(32'h5B5A5958));
    end

    // Continuous stream with packet ends every 1..7 beats; first packets single-beat
    streaming = 1'b1;
    left = 64;
    len  = 0;
    for (int i = 0; i < 64; i++) begin
      if (len == 0) len = (i < 4) ? 1 : int'($urandom_range(1, 7));
      len--;
      send(8'($urandom_range(0, 255)), (len == 0) || (i == 63));
      if (len == 0) left = 63 - i;
    end
    streaming = 1'b0;
    chk("stream_stalls", 64'(stalls), 64'(0));
    tick(); tick();

    // Reset with two lanes assembled
    send(8'h61, 0); send(8'h62, 0);
    rst = 1'b1; #1;
    chk("rst1_valid", 64'(m_valid_le), 64'(0));
    chk("rst1_ready", 64'(s_ready_le), 64'(0));
    tick(); rst = 1'b0;
    chk("rst1_ready_hold", 64'(s_ready_le), 64'(0));
    tick();

    // Reset with the output full
    m_ready = 1'b0;
    send(8'h71, 0); send(8'h72, 1);
    chk_word("rst2_pre", 32'h00007271, 4'b0011, 1'b1);
    rst = 1'b1; #1;
    chk("rst2_valid", 64'(m_valid_le), 64'(0));
    chk("rst2_data", 64'(m_data_le), 64'(0));
    chk("rst2_keep", 64'(m_keep_le), 64'(0));
    tick(); rst = 1'b0;
    chk("rst2_ready_hold", 64'(s_ready_le), 64'(0));
    tick();
    m_ready = 1'b1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    chk_word("after_rst", 32'h04030201, 4'b1111, 1'b0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stream_pack_upsizer.md
# stream_pack_upsizer

Width-converting stream packer: gathers SCALE narrow beats of DW_IN bits into one DW_IN*SCALE-bit word, with packet-aware partial flushing. It extends the plain upsizer with end-of-packet (last) handling, per-lane keep flags, an explicit flush request and a registered output stage, so a full-rate input sustains one output word every SCALE cycles. It sits between narrow sources (sensor/byte streams) and wide consumers (memory writers, wide FIFOs).

## Interface
- DW_IN, 8, input beat width in bits (≥1)
- SCALE, 4, lanes per output word (≥2)
- BIG_ENDIAN, 0, 0: first accepted beat in lane 0 (LSBs); 1: first beat in lane SCALE-1 (MSBs); keep bits follow the same lane mapping
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_data_i  in  DW_IN  input beat
- s_valid_i  in  1  input beat valid
- s_last_i  in  1  beat is last of packet; qualified by s_valid_i
- s_ready_o  out  1  input accept
- flush_i  in  1  single-cycle request to emit the partially assembled word
- m_data_o  out  DW_IN*SCALE  packed word; unfilled lanes zero
- m_keep_o  out  SCALE  one bit per lane, 1 = lane holds valid data
- m_last_o  out  1  word ends a packet
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  output accept

## Operation
- Two storage stages: assembly register (data, lane mask, idx counter 0..SCALE-1) and output register (data, keep, last, full flag).
- wr = s_valid_i & s_ready_o; rd = m_valid_o & m_ready_i.
- s_ready_o = !rst_r & (!out_full | m_ready_i); independent of s_valid_i/s_last_i.
- On wr: lane idx ← s_data_i, mask bit idx ← 1. Word completes if idx == SCALE-1 or s_last_i.
- On completion: assembly data/mask (including this beat) move into output register, keep ← mask, last ← s_last_i, out_full ← 1; assembly data, mask and idx cleared to 0.
- Otherwise idx ← idx+1.
- flush_i sets flush_pend. Flush executes in the first cycle where flush_pend (or flush_i) is set and (!out_full | rd): if mask ≠ 0, assembly (plus any beat accepted that same cycle) moves to output with last = s_last_i of that beat, else 0; if mask = 0 and no beat accepted, nothing emitted. flush_pend clears on execution.
- flush_i while flush_pend already set: no extra effect.
- rd with no new load: out_full ← 0. rd and load same cycle: out_full stays 1, new word presented.
- BIG_ENDIAN reverses lane order of both m_data_o and m_keep_o at the output only; idx always counts up.

## Timing
- Reset values: s_ready_o 0, m_valid_o 0, m_data_o 0, m_keep_o 0, m_last_o 0; idx 0, mask 0, flush_pend 0; rst_r 1.
- First cycle after rst deassertion: s_ready_o 0 (rst_r), high from the second cycle.
- Latency: completing beat accepted at edge N → m_valid_o high after edge N, i.e. word visible in cycle N+1.
- Throughput: continuous s_valid_i with m_ready_i = 1 → s_ready_o never drops; one word per SCALE beats; packets of length 1 → one word per cycle.
- m_valid_o held with m_data_o/m_keep_o/m_last_o stable until rd.
- Backpressure: out_full & !m_ready_i → s_ready_o 0, no beat accepted, assembly frozen.
- Reset mid-operation: assembly and output discarded immediately, outputs to reset values.

## Test plan
- DW_IN=8, SCALE=4, BIG_ENDIAN=0: feed 0x11,0x22,0x33,0x44 back-to-back, m_ready_i=1 → one word 0x44332211, keep 4'b1111, last 0, valid exactly one cycle after 0x44 accepted.
- Packet 0xA1,0xA2 with last on 0xA2 → word 0x0000A2A1, keep 4'b0011, last 1; next beat 0xB1 lands in lane 0.
- BIG_ENDIAN=1, beats 0x11,0x22,0x33 then flush_i pulse → 0x11223300, keep 4'b1110, last 0; flush_i with empty assembly → no output.
- Hold m_ready_i=0 with word pending, drive 12 beats → s_ready_o 0 while output full, no data lost; release → words emitted in order, 12 beats in 3 words.
- Continuous 64 beats with m_ready_i=1, random last every 1-7 beats → s_ready_o constantly 1, keep/last match reference model, no bubbles on single-beat packets.
- Assert rst with 2 lanes assembled and output full → m_valid_o 0 at once; after release s_ready_o 0 one cycle, then 0x01..0x04 → 0x04030201.
